// File: rtl/vga_timing_gen.sv
// Raster timing generator for a VGA display path: pixel/line counters, registered syncs,
// a display-enable, and once-per-frame pulses for game logic.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic       vblank_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // 11-bit compare constants so a sync window ending exactly at 1024 does not wrap.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] V_VIS_LAST = 11'(V_VISIBLE - 1);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_frame_start;
    logic       r_vblank_start;

    logic [9:0] w_hc_nxt;
    logic [9:0] w_vc_nxt;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_hs_nxt;
    logic       w_vs_nxt;
    logic       w_blank_nxt;
    logic       w_frame_start_nxt;
    logic       w_vblank_start_nxt;

    always_comb begin
        w_h_wrap = ({1'b0, r_hc} == H_LAST);
        w_v_wrap = ({1'b0, r_vc} == V_LAST);
        w_hc_nxt = r_hc;
        w_vc_nxt = r_vc;
        if (pix_en) begin
            if (w_h_wrap) begin
                w_hc_nxt = '0;
                w_vc_nxt = w_v_wrap ? '0 : r_vc + 10'd1;
            end else begin
                w_hc_nxt = r_hc + 10'd1;
            end
        end

        // Syncs and blank follow the next position so they line up with DrawX/DrawY.
        w_hs_nxt    = !(({1'b0, w_hc_nxt} >= H_SYNC_BEG) && ({1'b0, w_hc_nxt} < H_SYNC_END));
        w_vs_nxt    = !(({1'b0, w_vc_nxt} >= V_SYNC_BEG) && ({1'b0, w_vc_nxt} < V_SYNC_END));
        w_blank_nxt = ({1'b0, w_hc_nxt} < H_VIS) && ({1'b0, w_vc_nxt} < V_VIS);

        w_frame_start_nxt  = pix_en && w_h_wrap && w_v_wrap;
        w_vblank_start_nxt = pix_en && w_h_wrap && ({1'b0, r_vc} == V_VIS_LAST);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc           <= '0;
            r_vc           <= '0;
            r_hs           <= 1'b1;
            r_vs           <= 1'b1;
            r_blank        <= 1'b1;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
        end else begin
            r_hc           <= w_hc_nxt;
            r_vc           <= w_vc_nxt;
            r_hs           <= w_hs_nxt;
            r_vs           <= w_vs_nxt;
            r_blank        <= w_blank_nxt;
            r_frame_start  <= w_frame_start_nxt;
            r_vblank_start <= w_vblank_start_nxt;
        end
    end

    assign DrawX        = r_hc;
    assign DrawY        = r_vc;
    assign hs           = r_hs;
    assign vs           = r_vs;
    assign blank        = r_blank;
    assign frame_start  = r_frame_start;
    assign vblank_start = r_vblank_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance for line timing, a tiny-raster instance
// for whole-frame behaviour, and a 320x240 override instance for line period.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic pix_en;

    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_blank, d_fs, d_vb;
    logic [9:0] s_x, s_y;
    logic       s_hs, s_vs, s_blank, s_fs, s_vb;
    logic [9:0] o_x, o_y;
    logic       o_hs, o_vs, o_blank, o_fs, o_vb;

    vga_timing_gen u_dut (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_blank),
        .frame_start(d_fs), .vblank_start(d_vb)
    );

    // 15 x 10 raster: hs low at x 10..12, vs low at y 7..8, visible 8 x 6, frame 150 cycles.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_small (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .frame_start(s_fs), .vblank_start(s_vb)
    );

    vga_timing_gen #(
        .H_VISIBLE(320), .V_VISIBLE(240)
    ) u_ovr (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .DrawX(o_x), .DrawY(o_y), .hs(o_hs), .vs(o_vs), .blank(o_blank),
        .frame_start(o_fs), .vblank_start(o_vb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    typedef struct {
        int adv;
        int x;
        int y;
        int hs;
        int vs;
        int blank;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fs_t[$];
        int vb_t[$];
        int vs_low, blank_n, o_line, o_blank_n, vb_x, vb_y, errs, en, lin, fs_first;

        // Cumulative positions from reset release: 0,1,639,640,655,656,751,752,799,(0,1),(1,1).
        vecs[0]  = '{0,   0,   0, 1, 1, 1};
        vecs[1]  = '{1,   1,   0, 1, 1, 1};
        vecs[2]  = '{638, 639, 0, 1, 1, 1};
        vecs[3]  = '{1,   640, 0, 1, 1, 0};
        vecs[4]  = '{15,  655, 0, 1, 1, 0};
        vecs[5]  = '{1,   656, 0, 0, 1, 0};
        vecs[6]  = '{95,  751, 0, 0, 1, 0};
        vecs[7]  = '{1,   752, 0, 1, 1, 0};
        vecs[8]  = '{47,  799, 0, 1, 1, 0};
        vecs[9]  = '{1,   0,   1, 1, 1, 1};
        vecs[10] = '{1,   1,   1, 1, 1, 1};

        reset_n = 1'b0;
        pix_en  = 1'b1;
        repeat (5) step();
        check("rst_x", d_x, 0);
        check("rst_y", d_y, 0);
        check("rst_hs", d_hs, 1);
        check("rst_vs", d_vs, 1);
        check("rst_blank", d_blank, 1);
        check("rst_fs", d_fs, 0);
        check("rst_vb", d_vb, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            repeat (vecs[i].adv) step();
            check($sformatf("line%0d_x", i), d_x, vecs[i].x);
            check($sformatf("line%0d_y", i), d_y, vecs[i].y);
            check($sformatf("line%0d_hs", i), d_hs, vecs[i].hs);
            check($sformatf("line%0d_vs", i), d_vs, vecs[i].vs);
            check($sformatf("line%0d_blank", i), d_blank, vecs[i].blank);
            check($sformatf("line%0d_fs", i), d_fs, 0);
        end

        // Full frames on the tiny raster, plus line period on the override instance.
        reset_pulse();
        vs_low = 0; blank_n = 0; o_line = -1; o_blank_n = 0; vb_x = -1; vb_y = -1;
        for (int t = 0; t < 500; t++) begin
            if (t < 300) begin
                if (!s_vs) vs_low++;
                if (s_blank) blank_n++;
            end
            if (s_fs) fs_t.push_back(t);
            if (s_vb) begin
                vb_t.push_back(t);
                if (vb_t.size() == 1) begin
                    vb_x = int'(s_x);
                    vb_y = int'(s_y);
                end
            end
            if (t < 480 && o_blank) o_blank_n++;
            if (t > 0 && o_line < 0 && o_x == 10'd0) o_line = t;
            step();
        end
        check("frame_fs_count", fs_t.size(), 3);
        if (fs_t.size() >= 2) begin
            check("frame_fs_first", fs_t[0], 150);
            check("frame_fs_period", fs_t[1] - fs_t[0], 150);
        end
        check("frame_vb_count", vb_t.size(), 3);
        if (vb_t.size() >= 1) check("frame_vb_first", vb_t[0], 90);
        check("frame_vb_x", vb_x, 0);
        check("frame_vb_y", vb_y, 6);
        check("frame_vs_low", vs_low, 60);
        check("frame_blank", blank_n, 96);
        check("ovr_line_period", o_line, 480);
        check("ovr_line_blank", o_blank_n, 320);

        // Half rate: pix_en high on odd cycles after release.
        reset_pulse();
        fs_t.delete();
        errs = 0;
        for (int k = 1; k <= 620; k++) begin
            pix_en = (k % 2 == 1);
            step();
            en  = (k + 1) / 2;
            lin = en % 150;
            if (int'(s_x) != lin % 15 || int'(s_y) != lin / 15) errs++;
            if (s_fs) fs_t.push_back(k);
        end
        pix_en = 1'b1;
        check("half_pos_errs", errs, 0);
        check("half_fs_count", fs_t.size(), 2);
        if (fs_t.size() >= 2) begin
            check("half_fs_first", fs_t[0], 299);
            check("half_fs_period", fs_t[1] - fs_t[0], 300);
        end

        // Mid-frame asynchronous reset on the tiny raster.
        reset_pulse();
        repeat (50) step();
        check("mid_pre_x", s_x, 5);
        check("mid_pre_y", s_y, 3);
        #3 reset_n = 1'b0;
        #1;
        check("mid_async_x", s_x, 0);
        check("mid_async_y", s_y, 0);
        check("mid_async_hs", s_hs, 1);
        check("mid_async_vs", s_vs, 1);
        check("mid_async_blank", s_blank, 1);
        check("mid_async_dx", d_x, 0);
        step();
        step();
        reset_n = 1'b1;
        check("mid_release_fs", s_fs, 0);
        fs_first = -1;
        for (int t = 1; t <= 160; t++) begin
            step();
            if (s_fs && fs_first < 0) fs_first = t;
        end
        check("mid_next_fs", fs_first, 150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
